lc3_mem_arbiter: RTL and testbench
==================================

LC3_MEM_ARBITER -- requirements
Module: lc3_mem_arbiter

Interface
REQ-001 Parameter ADDR_W, 16, word-address width of shared SPRAM.
REQ-002 Parameter STARVE_LIMIT, 255, max cycles a pending CPU request may wait before cpu_starved sets.
REQ-003 Clock  input  1  single clock; all logic on posedge Clock.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 host_req / host_we  input  1/1  program-interface access request, write enable.
REQ-006 host_addr / host_wdata  input  16/16  program-interface address, write data.
REQ-007 host_lock  input  1  high = host exclusive (load/dump in progress); CPU grants blocked.
REQ-008 host_ack / host_rdata  output  1/16  one-cycle completion pulse; read data valid with ack.
REQ-009 cpu_req / cpu_we / cpu_addr / cpu_wdata  input  1/1/16/16  LC3 core access request.
REQ-010 cpu_ack / cpu_rdata  output  1/16  one-cycle completion pulse; read data valid with ack.
REQ-011 mem_addr / mem_wdata / mem_wren  output  16/16/1  SPRAM port.
REQ-012 mem_rdata  input  16  SPRAM read data, valid one cycle after mem_addr.
REQ-013 cpu_starved  output  1  sticky starvation flag.
REQ-014 busy  output  1  high in any state other than IDLE.

Function
REQ-015 FSM states: IDLE, ACCESS, RESP; one access in flight at a time.
REQ-016 IDLE: sample requests; no eligible request -> stay IDLE, mem_wren 0.
REQ-017 Eligibility: host eligible when host_req; CPU eligible when cpu_req and not host_lock.
REQ-018 Both eligible -> round robin: grant requester not granted last; after reset, host first.
REQ-019 Grant cycle N (IDLE): latch owner, addr, wdata, we; go ACCESS.
REQ-020 ACCESS, cycle N+1: mem_addr = latched addr, mem_wdata = latched data, mem_wren = latched we for exactly this cycle; go RESP.
REQ-021 RESP, cycle N+2: owner's ack = 1 for one cycle; owner's rdata = mem_rdata (read), unchanged (write); go IDLE.
REQ-022 Throughput: one access per 3 cycles; request-to-ack latency 2 cycles when uncontended.
REQ-023 Requester holds req, addr, we, wdata stable until ack; arbiter samples only in IDLE.
REQ-024 Requester may drop req in the ack cycle; req still high in the IDLE after ack is a new request.
REQ-025 mem_wren never high outside ACCESS; mem_addr holds last value in other states.
REQ-026 host_lock rising while a CPU access is in ACCESS/RESP: that access completes normally.
REQ-027 Starvation counter: 8-bit saturating; increments each cycle cpu_req high without cpu_ack; clears on cpu_ack or cpu_req low.
REQ-028 Counter reaching STARVE_LIMIT sets cpu_starved; cleared only by reset.
REQ-029 Addresses pass through unmodified; no range checking.

Reset
REQ-030 reset high at any clock edge: state IDLE, acks 0, rdata 0, mem_wren 0, mem_addr 0, mem_wdata 0, last-grant = CPU, counter 0, cpu_starved 0.
REQ-031 Reset mid-access aborts the access: no ack issued, mem_wren low from next cycle.

Structure
REQ-032 Shared package lc3_mem_pkg holds FSM state encoding, owner IDs (OWN_HOST, OWN_CPU), default STARVE_LIMIT.
REQ-033 One sub-module, lc3_rr_arb2: two-input round-robin grant with last-grant register.

Verification
REQ-034 Host write 0x3000<-0x1234 then read 0x3000 -> mem_wren one cycle at N+1; host_ack at N+2 both times; host_rdata 0x1234.
REQ-035 host_req and cpu_req rise in the same cycle, both held -> after reset grants alternate host, CPU, host; each ack 3 cycles apart.
REQ-036 host_lock=1, cpu_req held, host idle -> no cpu_ack, no mem_wren; cpu_starved=1 after 255 cycles; lock drop -> cpu_ack 2 cycles later, flag stays 1.
REQ-037 reset asserted in ACCESS of CPU write to 0x4000 -> no cpu_ack; mem_wren 0 from next cycle; all outputs at reset values.
REQ-038 CPU read 0xFE00 while host_lock rises in ACCESS -> cpu_ack at N+2 with SPRAM data; next host request granted immediately.

Source files
------------

// File: rtl/lc3_mem_pkg.sv
// Shared definitions for the LC3 shared-SPRAM arbiter: FSM encoding, owner IDs, defaults.
package lc3_mem_pkg;

  localparam int unsigned DATA_W               = 16;
  localparam int unsigned STARVE_CNT_W         = 8;
  localparam int unsigned DEFAULT_STARVE_LIMIT = 255;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } arb_state_e;

  typedef enum logic {
    OWN_HOST = 1'b0,
    OWN_CPU  = 1'b1
  } owner_e;

endpackage

// File: rtl/lc3_rr_arb2.sv
// Two-requester round-robin grant; the last-grant register only moves when a grant is taken.
module lc3_rr_arb2
  import lc3_mem_pkg::*;
(
  input  logic Clock,
  input  logic reset,
  input  logic req_host,
  input  logic req_cpu,
  input  logic take,
  output logic grant_host_c,
  output logic grant_cpu_c
);

  owner_e last_q;

  // On contention the requester that was not granted last wins
  always_comb begin
    grant_host_c = req_host && (!req_cpu || (last_q == OWN_CPU));
    grant_cpu_c  = req_cpu  && (!req_host || (last_q == OWN_HOST));
  end

  // Reset to CPU so the host wins the first contended grant
  always_ff @(posedge Clock) begin
    if (reset) begin
      last_q <= OWN_CPU;
    end else if (take && grant_host_c) begin
      last_q <= OWN_HOST;
    end else if (take && grant_cpu_c) begin
      last_q <= OWN_CPU;
    end
  end

endmodule

// File: rtl/lc3_mem_arbiter.sv
// Shares one single-port RAM between the program (host) interface and the LC3 core.
// One access in flight: IDLE (grant) -> ACCESS (RAM cycle) -> RESP (ack).
module lc3_mem_arbiter
  import lc3_mem_pkg::*;
#(
  parameter int unsigned ADDR_W       = 16,
  parameter int unsigned STARVE_LIMIT = DEFAULT_STARVE_LIMIT
) (
  input  logic              Clock,
  input  logic              reset,
  input  logic              host_req,
  input  logic              host_we,
  input  logic [ADDR_W-1:0] host_addr,
  input  logic [DATA_W-1:0] host_wdata,
  input  logic              host_lock,
  output logic              host_ack,
  output logic [DATA_W-1:0] host_rdata,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_ack,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_wren,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              cpu_starved,
  output logic              busy
);

  arb_state_e              state_q, state_d;
  owner_e                  own_q, own_d;
  logic                    we_q, we_d;
  logic [ADDR_W-1:0]       mem_addr_d;
  logic [DATA_W-1:0]       mem_wdata_d;
  logic                    mem_wren_d;
  logic                    host_ack_d, cpu_ack_d;
  logic [DATA_W-1:0]       host_rdata_q, cpu_rdata_q;
  logic                    rd_host_c, rd_cpu_c;
  logic                    grant_host_c, grant_cpu_c;
  logic [STARVE_CNT_W-1:0] cnt_q, cnt_d;
  logic                    starve_hit_c;

  lc3_rr_arb2 u_rr (
    .Clock        (Clock),
    .reset        (reset),
    .req_host     (host_req),
    .req_cpu      (cpu_req && !host_lock),
    .take         (state_q == ST_IDLE),
    .grant_host_c (grant_host_c),
    .grant_cpu_c  (grant_cpu_c)
  );

  // Next state and next registered outputs
  always_comb begin
    state_d     = state_q;
    own_d       = own_q;
    we_d        = we_q;
    mem_addr_d  = mem_addr;
    mem_wdata_d = mem_wdata;
    mem_wren_d  = 1'b0;
    host_ack_d  = 1'b0;
    cpu_ack_d   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (grant_host_c) begin
          own_d       = OWN_HOST;
          we_d        = host_we;
          mem_addr_d  = host_addr;
          mem_wdata_d = host_wdata;
          mem_wren_d  = host_we;
          state_d     = ST_ACCESS;
        end else if (grant_cpu_c) begin
          own_d       = OWN_CPU;
          we_d        = cpu_we;
          mem_addr_d  = cpu_addr;
          mem_wdata_d = cpu_wdata;
          mem_wren_d  = cpu_we;
          state_d     = ST_ACCESS;
        end
      end
      ST_ACCESS: begin
        host_ack_d = (own_q == OWN_HOST);
        cpu_ack_d  = (own_q == OWN_CPU);
        state_d    = ST_RESP;
      end
      ST_RESP: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // RAM data only becomes valid in RESP, so read data bypasses its holding register then
  always_comb begin
    rd_host_c  = (state_q == ST_RESP) && (own_q == OWN_HOST) && !we_q;
    rd_cpu_c   = (state_q == ST_RESP) && (own_q == OWN_CPU) && !we_q;
    host_rdata = rd_host_c ? mem_rdata : host_rdata_q;
    cpu_rdata  = rd_cpu_c ? mem_rdata : cpu_rdata_q;
  end

  always_ff @(posedge Clock) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      own_q        <= OWN_CPU;
      we_q         <= 1'b0;
      mem_addr     <= '0;
      mem_wdata    <= '0;
      mem_wren     <= 1'b0;
      host_ack     <= 1'b0;
      cpu_ack      <= 1'b0;
      host_rdata_q <= '0;
      cpu_rdata_q  <= '0;
      busy         <= 1'b0;
    end else begin
      state_q      <= state_d;
      own_q        <= own_d;
      we_q         <= we_d;
      mem_addr     <= mem_addr_d;
      mem_wdata    <= mem_wdata_d;
      mem_wren     <= mem_wren_d;
      host_ack     <= host_ack_d;
      cpu_ack      <= cpu_ack_d;
      host_rdata_q <= host_rdata;
      cpu_rdata_q  <= cpu_rdata;
      busy         <= (state_d != ST_IDLE);
    end
  end

  // Saturating wait counter for a pending CPU request
  always_comb begin
    cnt_d = cnt_q;
    if (!cpu_req || cpu_ack) begin
      cnt_d = '0;
    end else if (cnt_q != {STARVE_CNT_W{1'b1}}) begin
      cnt_d = cnt_q + STARVE_CNT_W'(1);
    end
    starve_hit_c = (32'(cnt_d) >= STARVE_LIMIT);
  end

  always_ff @(posedge Clock) begin
    if (reset) begin
      cnt_q       <= '0;
      cpu_starved <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      cpu_starved <= cpu_starved | starve_hit_c;
    end
  end

endmodule

// File: tb/tb_lc3_mem_arbiter.sv
// Directed bench for lc3_mem_arbiter with an ack scoreboard and a behavioural SPRAM.
module tb_lc3_mem_arbiter;

  logic        Clock;
  logic        reset;
  logic        host_req, host_we, host_lock;
  logic [15:0] host_addr, host_wdata;
  logic        host_ack;
  logic [15:0] host_rdata;
  logic        cpu_req, cpu_we;
  logic [15:0] cpu_addr, cpu_wdata;
  logic        cpu_ack;
  logic [15:0] cpu_rdata;
  logic [15:0] mem_addr, mem_wdata, mem_rdata;
  logic        mem_wren;
  logic        cpu_starved, busy;

  typedef struct {
    logic        own_cpu;
    int          cyc;
    logic [15:0] rdata;
  } exp_t;

  exp_t        sbq[$];
  int          n_cmp = 0;
  int          n_fail = 0;
  int          cyc = 0;
  logic [15:0] spram [0:65535];

  lc3_mem_arbiter dut (
    .Clock       (Clock),
    .reset       (reset),
    .host_req    (host_req),
    .host_we     (host_we),
    .host_addr   (host_addr),
    .host_wdata  (host_wdata),
    .host_lock   (host_lock),
    .host_ack    (host_ack),
    .host_rdata  (host_rdata),
    .cpu_req     (cpu_req),
    .cpu_we      (cpu_we),
    .cpu_addr    (cpu_addr),
    .cpu_wdata   (cpu_wdata),
    .cpu_ack     (cpu_ack),
    .cpu_rdata   (cpu_rdata),
    .mem_addr    (mem_addr),
    .mem_wdata   (mem_wdata),
    .mem_wren    (mem_wren),
    .mem_rdata   (mem_rdata),
    .cpu_starved (cpu_starved),
    .busy        (busy)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  always @(posedge Clock) cyc <= cyc + 1;

  // Registered-read SPRAM: data for mem_addr appears one cycle later
  always @(posedge Clock) begin
    if (mem_wren) spram[mem_addr] <= mem_wdata;
    mem_rdata <= spram[mem_addr];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge Clock);
  endtask

  task automatic expect_ack(input logic own_cpu, input int at, input logic [15:0] rd);
    exp_t e;
    e.own_cpu = own_cpu;
    e.cyc     = at;
    e.rdata   = rd;
    sbq.push_back(e);
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_host_ack"},   32'(host_ack),    32'(0));
    chk({tag, "_cpu_ack"},    32'(cpu_ack),     32'(0));
    chk({tag, "_host_rdata"}, 32'(host_rdata),  32'(0));
    chk({tag, "_cpu_rdata"},  32'(cpu_rdata),   32'(0));
    chk({tag, "_mem_wren"},   32'(mem_wren),    32'(0));
    chk({tag, "_mem_addr"},   32'(mem_addr),    32'(0));
    chk({tag, "_mem_wdata"},  32'(mem_wdata),   32'(0));
    chk({tag, "_starved"},    32'(cpu_starved), 32'(0));
    chk({tag, "_busy"},       32'(busy),        32'(0));
  endtask

  task automatic reset_pulse();
    reset = 1'b1;
    tick(2);
    check_reset_vals("rst");
    reset = 1'b0;
  endtask

  // Scoreboard: every ack must match the oldest expectation in owner, cycle and read data
  always @(negedge Clock) begin
    exp_t e;
    if (sbq.size() != 0 && cyc > sbq[0].cyc) begin
      chk("ack_missing", 32'(cyc), 32'(sbq[0].cyc));
      void'(sbq.pop_front());
    end
    if (host_ack || cpu_ack) begin
      if (sbq.size() == 0) begin
        chk("ack_unexpected", 32'({host_ack, cpu_ack}), 32'(0));
      end else begin
        e = sbq.pop_front();
        chk("ack_host", 32'(host_ack), 32'(!e.own_cpu));
        chk("ack_cpu",  32'(cpu_ack),  32'(e.own_cpu));
        chk("ack_cycle", 32'(cyc), 32'(e.cyc));
        chk("ack_rdata", 32'(e.own_cpu ? cpu_rdata : host_rdata), 32'(e.rdata));
      end
    end
  end

  initial begin
    logic wren_seen;
    reset = 1'b1;
    host_req = 1'b0; host_we = 1'b0; host_addr = '0; host_wdata = '0; host_lock = 1'b0;
    cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
    tick(3);
    reset_pulse();

    // Host write 0x3000 <- 0x1234, then read it back, then seed 0xFE00
    host_req = 1'b1; host_we = 1'b1; host_addr = 16'h3000; host_wdata = 16'h1234;
    expect_ack(1'b0, cyc + 2, 16'h0000);
    tick(1);
    chk("wr_wren",  32'(mem_wren),  32'(1));
    chk("wr_addr",  32'(mem_addr),  32'h3000);
    chk("wr_wdata", 32'(mem_wdata), 32'h1234);
    chk("wr_busy",  32'(busy),      32'(1));
    tick(1);
    chk("wr_wren_off", 32'(mem_wren), 32'(0));
    chk("wr_addr_hold", 32'(mem_addr), 32'h3000);
    host_req = 1'b0;
    tick(1);
    chk("idle_busy", 32'(busy), 32'(0));
    host_req = 1'b1; host_we = 1'b0;
    expect_ack(1'b0, cyc + 2, 16'h1234);
    tick(1);
    chk("rd_wren", 32'(mem_wren), 32'(0));
    tick(1);
    host_req = 1'b0;
    tick(1);
    host_req = 1'b1; host_we = 1'b1; host_addr = 16'hFE00; host_wdata = 16'hCAFE;
    expect_ack(1'b0, cyc + 2, 16'h1234);
    tick(2);
    host_req = 1'b0;
    tick(1);

    // Simultaneous requests alternate host, CPU, host starting from reset
    reset_pulse();
    host_req = 1'b1; host_we = 1'b0; host_addr = 16'h3000;
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 16'h4000; cpu_wdata = 16'hBEEF;
    expect_ack(1'b0, cyc + 2, 16'h1234);
    expect_ack(1'b1, cyc + 5, 16'h0000);
    expect_ack(1'b0, cyc + 8, 16'h1234);
    tick(5);
    cpu_req = 1'b0;
    tick(3);
    host_req = 1'b0;
    tick(1);
    chk("rr_idle", 32'(busy), 32'(0));

    // Host lock starves a CPU read; flag sets at the 255th waiting cycle and sticks
    reset_pulse();
    host_lock = 1'b1;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'hFE00;
    wren_seen = 1'b0;
    for (int i = 0; i < 254; i++) begin
      tick(1);
      if (mem_wren) wren_seen = 1'b1;
    end
    chk("starve_before", 32'(cpu_starved), 32'(0));
    tick(1);
    chk("starve_at_limit", 32'(cpu_starved), 32'(1));
    chk("lock_no_wren", 32'(wren_seen), 32'(0));
    chk("lock_busy", 32'(busy), 32'(0));
    host_lock = 1'b0;
    expect_ack(1'b1, cyc + 2, 16'hCAFE);
    tick(2);
    cpu_req = 1'b0;
    tick(1);
    chk("starve_sticky", 32'(cpu_starved), 32'(1));

    // Reset during the ACCESS cycle of a CPU write aborts it
    reset_pulse();
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 16'h4000; cpu_wdata = 16'h5555;
    tick(1);
    chk("abort_wren", 32'(mem_wren), 32'(1));
    chk("abort_addr", 32'(mem_addr), 32'h4000);
    reset = 1'b1;
    tick(1);
    check_reset_vals("abort");
    reset = 1'b0;
    cpu_req = 1'b0;
    tick(3);

    // CPU read completes despite host_lock rising mid-access; host follows at once
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'hFE00;
    expect_ack(1'b1, cyc + 2, 16'hCAFE);
    tick(1);
    host_lock = 1'b1;
    host_req = 1'b1; host_we = 1'b0; host_addr = 16'h3000;
    expect_ack(1'b0, cyc + 4, 16'h1234);
    tick(1);
    cpu_req = 1'b0;
    tick(2);
    chk("host_next_addr", 32'(mem_addr), 32'h3000);
    chk("host_next_busy", 32'(busy), 32'(1));
    tick(1);
    host_req = 1'b0;
    host_lock = 1'b0;
    tick(3);

    chk("pending_acks", 32'(sbq.size()), 32'(0));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
